keypad_matrix_scan: RTL and testbench

Parametrised keypad matrix scanner, the successor to the fixed 4x3 keypad scanner on the digio bank. It drives one active-low row at a time and samples active-low column inputs through a synchroniser. It keeps a per-frame key image, rejects multi-key/ghost frames and debounces across whole frames. Press and release events go into a small FIFO with a valid/ready handshake, so the video/menu logic in the `clk` domain consumes keys without missing or repeating them.

---
 rtl/keypad_matrix_scan.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: row-strobed keypad scanner with whole-frame debounce.
// Single-key detection, ghost rejection and a valid/ready event FIFO.
//
// Ports:
//   clk       system clock
//   reset_n   synchronous active-low reset
//   row_n     active-low row drive, one row low at a time
//   col_n     active-low column sense (asynchronous)
//   ev_valid  event available at FIFO head
//   ev_data   {press, key index} of the head event
//   ev_ready  consumer pops the head when ev_valid is high
//   key_down  a debounced key is currently held
//   key_code  index of the last debounced pressed key
//   overflow  sticky flag: an event was dropped on a full FIFO
//   ovf_clr   clears overflow (a same-cycle drop wins)

module keypad_matrix_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 3,
    parameter int DIV_W      = 10,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CODE_W     = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ROWS-1:0]   row_n,
    input  logic [COLS-1:0]   col_n,
    output logic              ev_valid,
    output logic [CODE_W:0]   ev_data,
    input  logic              ev_ready,
    output logic              key_down,
    output logic [CODE_W-1:0] key_code,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0]  DWELL_LAST = '1;
    localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS-1);
    localparam logic [CODE_W-1:0] COLS_C     = CODE_W'(COLS);
    localparam logic [3:0]        DEB        = 4'(DEBOUNCE);
    localparam logic [AW:0]       FULL_CNT   = (AW+1)'(FIFO_DEPTH);

    // ---------------------------------------------------------------
    // Row scan
    // ---------------------------------------------------------------
    logic [DIV_W-1:0] dwell_q;
    logic [RW-1:0]    row_q;
    logic [RW-1:0]    row_d;
    logic             sample;
    logic             frame_end;

    assign sample    = (dwell_q == DWELL_LAST);
    assign frame_end = sample && (row_q == ROW_LAST);

    always_comb begin
        row_d = row_q;
        if (sample) begin
            row_d = frame_end ? '0 : row_q + RW'(1);
        end
    end

    // row_n is loaded from the next row index so the drive and the
    // internal row index always agree.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dwell_q <= '0;
            row_q   <= '0;
            row_n   <= '1;
        end else begin
            dwell_q <= dwell_q + DIV_W'(1);
            row_q   <= row_d;
            row_n   <= ~(ROWS'(1) << row_d);
        end
    end

    // ---------------------------------------------------------------
    // Column synchroniser (idles high, i.e. no key)
    // ---------------------------------------------------------------
    logic [COLS-1:0] sync1_q;
    logic [COLS-1:0] sync2_q;
    logic [COLS-1:0] pressed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // ---------------------------------------------------------------
    // Per-row decode: count saturates at 2 (= "many")
    // ---------------------------------------------------------------
    logic [1:0]        row_cnt;
    logic [CW-1:0]     row_col;
    logic [CODE_W-1:0] row_code;

    always_comb begin
        row_cnt = 2'd0;
        row_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (pressed[c]) begin
                row_col = CW'(c);
                if (row_cnt != 2'd2) begin
                    row_cnt = row_cnt + 2'd1;
                end
            end
        end
    end

    assign row_code = CODE_W'(row_q) * COLS_C + CODE_W'(row_col);

    // ---------------------------------------------------------------
    // Frame image: only the key count and the single key are needed
    // ---------------------------------------------------------------
    logic [1:0]        acc_cnt_q;
    logic [CODE_W-1:0] acc_code_q;
    logic [1:0]        tot_cnt;
    logic [CODE_W-1:0] tot_code;
    logic              cand_hit;
    logic [CODE_W-1:0] cand_code;

    always_comb begin
        tot_cnt  = acc_cnt_q;
        tot_code = acc_code_q;
        if (row_cnt != 2'd0) begin
            if (acc_cnt_q == 2'd0 && row_cnt == 2'd1) begin
                tot_cnt  = 2'd1;
                tot_code = row_code;
            end else begin
                tot_cnt  = 2'd2;
            end
        end
    end

    // Ghost/multi-key frames collapse to "none"; code is zeroed so
    // every "none" compares equal.
    assign cand_hit  = (tot_cnt == 2'd1);
    assign cand_code = cand_hit ? tot_code : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else if (sample) begin
            acc_cnt_q  <= frame_end ? 2'd0 : tot_cnt;
            acc_code_q <= frame_end ? '0 : tot_code;
        end
    end

    // ---------------------------------------------------------------
    // Frame-to-frame debounce
    // ---------------------------------------------------------------
    logic              prev_hit_q;
    logic [CODE_W-1:0] prev_code_q;
    logic [3:0]        stable_q;
    logic [3:0]        stable_d;
    logic              same;
    logic              differs;
    logic              accept;

    assign same = (cand_hit == prev_hit_q) &&
                  (cand_code == prev_code_q);

    always_comb begin
        stable_d = 4'd1;
        if (same) begin
            stable_d = (stable_q == DEB) ? stable_q
                                         : stable_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_hit_q  <= 1'b0;
            prev_code_q <= '0;
            stable_q    <= '0;
        end else if (frame_end) begin
            prev_hit_q  <= cand_hit;
            prev_code_q <= cand_code;
            stable_q    <= stable_d;
        end
    end

    assign differs = (cand_hit != key_down) ||
                     (cand_hit && cand_code != key_code);
    assign accept  = frame_end && (stable_d == DEB) && differs;

    // ---------------------------------------------------------------
    // Debounced key state
    // S_PEND: release already pushed, press of the new key goes next.
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              push;
    logic [CODE_W:0]   push_data;
    logic [CODE_W-1:0] pend_code_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_HELD;
            end
            S_HELD: begin
                if (accept) begin
                    state_d = cand_hit ? S_PEND : S_IDLE;
                end
            end
            S_PEND:  state_d = S_HELD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {1'b1, cand_code};
                end
            end
            S_HELD: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {1'b0, key_code};
                end
            end
            S_PEND: begin
                push      = 1'b1;
                push_data = {1'b1, pend_code_q};
            end
            default: ;
        endcase
    end

    assign key_down = (state_q == S_HELD);

    // key_code follows every press, even one the FIFO had to drop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_code    <= '0;
            pend_code_q <= '0;
        end else begin
            if (push && push_data[CODE_W]) begin
                key_code <= push_data[CODE_W-1:0];
            end
            if (state_q == S_HELD && accept && cand_hit) begin
                pend_code_q <= cand_code;
            end
        end
    end

    // ---------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------
    logic [CODE_W:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     cnt_q;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;

    assign full  = (cnt_q == FULL_CNT);
    assign pop   = ev_valid && ev_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign ev_valid = (cnt_q != '0);
    assign ev_data  = ev_valid ? mem_q[rd_q] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan (4x3, 16-cycle dwell,
// 2-frame debounce, 4-entry FIFO) with a modelled key matrix.

module tb_keypad_matrix_scan;

    logic       clk;
    logic       reset_n;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic       ev_valid;
    logic [4:0] ev_data;
    logic       ev_ready;
    logic       key_down;
    logic [3:0] key_code;
    logic       overflow;
    logic       ovf_clr;

    logic [11:0] keys;

    int checks = 0;
    int errors = 0;

    keypad_matrix_scan #(
        .ROWS       (4),
        .COLS       (3),
        .DIV_W      (4),
        .DEBOUNCE   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .key_down (key_down),
        .key_code (key_code),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a held key shorts its row to its column.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // From the negedge of cycle c to the negedge of cycle c+n.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        cycles(n * 64);
    endtask

    // Returns at the negedge of cycle 0 of the first frame.
    task automatic do_reset();
        reset_n  = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        keys     = '0;
        cycles(2);
        reset_n  = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [4:0] exp);
        chk({tag, " valid"}, 32'(ev_valid), 32'd1);
        chk({tag, " data"},  32'(ev_data),  32'(exp));
        ev_ready = 1'b1;
        cycles(1);
        ev_ready = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        keys     = '0;

        // Reset values and scan sequence
        cycles(2);
        chk("rst row_n",    32'(row_n),    32'hF);
        chk("rst ev_valid", 32'(ev_valid), 32'd0);
        chk("rst ev_data",  32'(ev_data),  32'd0);
        chk("rst key_down", 32'(key_down), 32'd0);
        chk("rst key_code", 32'(key_code), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        chk("scan c0",  32'(row_n), 32'hF);
        cycles(1);
        chk("scan c1",  32'(row_n), 32'hE);
        cycles(14);
        chk("scan c15", 32'(row_n), 32'hE);
        cycles(1);
        chk("scan c16", 32'(row_n), 32'hD);
        cycles(47);
        chk("scan c63", 32'(row_n), 32'h7);
        cycles(1);
        chk("scan c64", 32'(row_n), 32'hE);

        // Hold index 7 for 5 frames then release
        do_reset();
        keys = 12'h080;
        cycles(127);
        chk("t1 pre valid", 32'(ev_valid), 32'd0);
        chk("t1 pre down",  32'(key_down), 32'd0);
        cycles(1);
        chk("t1 valid",  32'(ev_valid), 32'd1);
        chk("t1 down",   32'(key_down), 32'd1);
        chk("t1 code",   32'(key_code), 32'd7);
        chk("t1 data",   32'(ev_data),  32'h17);
        cycles(192);
        chk("t1 held",   32'(key_down), 32'd1);
        keys = '0;
        frames(3);
        chk("t1 up",     32'(key_down), 32'd0);
        chk("t1 code2",  32'(key_code), 32'd7);
        pop_chk("t1 ev0", 5'h17);
        pop_chk("t1 ev1", 5'h07);
        chk("t1 empty",  32'(ev_valid), 32'd0);

        // One-frame bounce
        do_reset();
        keys = 12'h080;
        frames(1);
        keys = '0;
        frames(4);
        chk("t2 valid", 32'(ev_valid), 32'd0);
        chk("t2 down",  32'(key_down), 32'd0);

        // Ghost frame (index 0 + 5), then index 0 alone
        do_reset();
        keys = 12'h021;
        frames(4);
        chk("t3 ghost valid", 32'(ev_valid), 32'd0);
        chk("t3 ghost down",  32'(key_down), 32'd0);
        keys = 12'h001;
        frames(1);
        chk("t3 f1 valid", 32'(ev_valid), 32'd0);
        frames(1);
        chk("t3 f2 valid", 32'(ev_valid), 32'd1);
        chk("t3 f2 data",  32'(ev_data),  32'h10);
        chk("t3 f2 down",  32'(key_down), 32'd1);

        // Direct move 3 -> 11
        do_reset();
        keys = 12'h008;
        frames(3);
        keys = 12'h800;
        cycles(127);
        chk("t4 c319 down", 32'(key_down), 32'd1);
        chk("t4 c319 code", 32'(key_code), 32'd3);
        cycles(1);
        chk("t4 c320 down", 32'(key_down), 32'd0);
        chk("t4 c320 code", 32'(key_code), 32'd3);
        cycles(1);
        chk("t4 c321 down", 32'(key_down), 32'd1);
        chk("t4 c321 code", 32'(key_code), 32'd11);
        pop_chk("t4 ev0", 5'h13);
        pop_chk("t4 ev1", 5'h03);
        pop_chk("t4 ev2", 5'h1B);
        chk("t4 empty", 32'(ev_valid), 32'd0);

        // Overflow: five events into four slots
        do_reset();
        keys = 12'h002;
        frames(2);
        keys = '0;
        frames(2);
        keys = 12'h004;
        frames(2);
        keys = '0;
        frames(2);
        chk("t5 full ovf", 32'(overflow), 32'd0);
        keys = 12'h010;
        frames(2);
        chk("t5 ovf set",  32'(overflow), 32'd1);
        chk("t5 down",     32'(key_down), 32'd1);
        chk("t5 code",     32'(key_code), 32'd4);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        chk("t5 ovf clr",  32'(overflow), 32'd0);
        pop_chk("t5 ev0", 5'h11);
        pop_chk("t5 ev1", 5'h01);
        pop_chk("t5 ev2", 5'h12);
        pop_chk("t5 ev3", 5'h02);
        chk("t5 empty", 32'(ev_valid), 32'd0);

        // Reset mid-frame with key 4 held and two queued events
        do_reset();
        keys = 12'h002;
        frames(2);
        keys = 12'h010;
        frames(2);
        cycles(2);
        pop_chk("t6 ev0", 5'h11);
        cycles(20);
        chk("t6 pre down",  32'(key_down), 32'd1);
        chk("t6 pre code",  32'(key_code), 32'd4);
        chk("t6 pre data",  32'(ev_data),  32'h01);
        reset_n = 1'b0;
        cycles(1);
        chk("t6 row_n",    32'(row_n),    32'hF);
        chk("t6 valid",    32'(ev_valid), 32'd0);
        chk("t6 data",     32'(ev_data),  32'd0);
        chk("t6 down",     32'(key_down), 32'd0);
        chk("t6 code",     32'(key_code), 32'd0);
        chk("t6 overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cycles(1);
        chk("t6 rel row_n", 32'(row_n),    32'hE);
        cycles(63);
        chk("t6 post valid", 32'(ev_valid), 32'd0);
        chk("t6 post down",  32'(key_down), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
